// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the synchronous byte FIFO: pops the FIFO, hides its 1-cycle read
// latency behind a 2-entry buffer and emits a valid/ready stream with packet framing.
// Optional beat counter port rd_count is present only when FIFO_RD_CNT_EN is defined.
module fifo_read_ctrl #(
   parameter int DATA_W  = 8,
   parameter int PKT_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   output logic              fifo_read_en,
   input  logic [DATA_W-1:0] fifo_data_out,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0]       rd_count
`endif
);

   // Stream handshake: a beat transfers in every cycle where m_valid && m_ready; while
   // m_valid is high and m_ready low, m_valid, m_data and m_last hold their values.

   localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              inflight;
   logic              push;
   logic              pop;
   logic [1:0]        occ;
   logic [2:0]        level;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;
   logic [CNT_W-1:0]  cnt;

   assign occ     = state;
   assign push    = inflight;
   assign m_valid = (state != S_EMPTY);
   assign pop     = m_valid && m_ready;
   assign m_data  = head;
   assign m_last  = m_valid && (cnt == CNT_LAST);

   // Committed bytes after this cycle's pop; a new pop may only be issued while a slot remains.
   assign level        = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_read_en = !rst && enable && !fifo_empty && (level < 3'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_EMPTY;
         inflight <= 1'b0;
      end else begin
         state    <= state_next;
         inflight <= fifo_read_en;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_EMPTY: begin
            if (push) state_next = S_ONE;
         end
         S_ONE: begin
            if (push && !pop) begin
               state_next = S_TWO;
            end else if (pop && !push) begin
               state_next = S_EMPTY;
            end
         end
         S_TWO: begin
            if (pop) state_next = S_ONE;
         end
         default: state_next = S_EMPTY;
      endcase
   end

   // Buffer datapath: head is the oldest entry, tail only used when two entries are held.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (push) head <= fifo_data_out;
            end
            S_ONE: begin
               if (push && pop) begin
                  head <= fifo_data_out;
               end else if (push) begin
                  tail <= fifo_data_out;
               end
            end
            S_TWO: begin
               if (pop) head <= tail;
            end
            default: begin
               head <= head;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (pop) begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef FIFO_RD_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count <= 16'd0;
      end else if (pop) begin
         rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule
